// File: rtl/vlu_pkg.sv
// Shared constants and types for the vector load unit.
package vlu_pkg;

   localparam int unsigned LANES       = 16;
   localparam int unsigned DW          = 32;
   localparam int unsigned AW          = 32;
   localparam int unsigned RW          = 4;
   localparam int unsigned CW          = $clog2(LANES);
   localparam int unsigned SCALAR_LANE = LANES - 1;
   localparam logic [RW-1:0] PC_REG    = 4'd15;

   typedef logic [DW-1:0] lane_t;
   typedef lane_t [LANES-1:0] vec_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StWb
   } state_e;

   // Index of the final element: LANES-1 for a vector load, 0 for a scalar load.
   function automatic logic [CW-1:0] elem_last(input logic vec);
      return vec ? CW'(LANES - 1) : '0;
   endfunction

endpackage

// File: rtl/vlu_addr_gen.sv
// Issue counter and strided address accumulator for the vector load unit.
module vlu_addr_gen
   import vlu_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic          vec_i,
   input  logic [AW-1:0] base_i,
   input  logic [AW-1:0] stride_i,
   input  logic          adv_i,
   output logic [AW-1:0] addr_o,
   output logic          last_o
);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] stride_q, stride_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] lim_q, lim_d;

   assign addr_o = addr_q;
   assign last_o = (cnt_q == lim_q);

   // The address stops advancing on the last issue so it holds once mem_re drops.
   always_comb begin
      addr_d   = addr_q;
      stride_d = stride_q;
      cnt_d    = cnt_q;
      lim_d    = lim_q;
      if (load_i) begin
         addr_d   = base_i;
         stride_d = stride_i;
         cnt_d    = '0;
         lim_d    = elem_last(vec_i);
      end else if (adv_i && !last_o) begin
         addr_d = addr_q + stride_q;
         cnt_d  = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q   <= '0;
         stride_q <= '0;
         cnt_q    <= '0;
         lim_q    <= '0;
      end else begin
         addr_q   <= addr_d;
         stride_q <= stride_d;
         cnt_q    <= cnt_d;
         lim_q    <= lim_d;
      end
   end

endmodule

// File: rtl/vector_load_unit.sv
// Gathers 1 or 16 strided words from memory and issues one register-file write.
module vector_load_unit
   import vlu_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          vec_mode,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] stride,
   input  logic [RW-1:0] dest_reg,
   output logic          mem_re,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   output logic          rf_we,
   output logic [RW-1:0] rf_wa,
   output vec_t          rf_wd,
   output logic          rf_sel_v_s_w,
   output logic          busy,
   output logic          done,
   output logic          err
);

   state_e state_q, state_d;

   logic               vec_q, vec_d;
   logic [RW-1:0]      dest_q, dest_d;
   logic [MEM_LAT-1:0] vld_q, vld_d;
   logic [CW-1:0]      ptr_q, ptr_d;
   vec_t               buf_q, buf_d;

   logic               rf_we_q, rf_we_d;
   logic [RW-1:0]      rf_wa_q, rf_wa_d;
   vec_t               rf_wd_q, rf_wd_d;
   logic               rf_sel_q, rf_sel_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               ag_load;
   logic               ag_adv;
   logic               ag_last;
   logic [AW-1:0]      ag_addr;
   logic               cap;
   logic               final_cap;
   logic               suppress;
   logic [CW-1:0]      lane_idx;

   assign ag_load = (state_q == StIdle) && start;
   assign ag_adv  = (state_q == StIssue);

   vlu_addr_gen u_addr_gen (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (ag_load),
      .vec_i    (vec_mode),
      .base_i   (base_addr),
      .stride_i (stride),
      .adv_i    (ag_adv),
      .addr_o   (ag_addr),
      .last_o   (ag_last)
   );

   assign mem_re       = (state_q == StIssue);
   assign mem_addr     = ag_addr;
   assign busy         = (state_q != StIdle);
   assign rf_we        = rf_we_q;
   assign rf_wa        = rf_wa_q;
   assign rf_wd        = rf_wd_q;
   assign rf_sel_v_s_w = rf_sel_q;
   assign done         = done_q;
   assign err          = err_q;

   // Oldest slot of the valid pipe marks the edge on which mem_rdata belongs to us.
   assign cap       = vld_q[MEM_LAT-1];
   assign final_cap = cap && (ptr_q == elem_last(vec_q));
   assign suppress  = !vec_q && (dest_q == PC_REG);
   assign lane_idx  = CW'(SCALAR_LANE) - ptr_q;

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      dest_d   = dest_q;
      ptr_d    = ptr_q;
      buf_d    = buf_q;
      vld_d    = vld_q << 1;
      vld_d[0] = mem_re;
      rf_we_d  = 1'b0;
      rf_wa_d  = rf_wa_q;
      rf_wd_d  = rf_wd_q;
      rf_sel_d = rf_sel_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      if (cap) begin
         buf_d[lane_idx] = mem_rdata;
         ptr_d           = ptr_q + CW'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StIssue;
               vec_d   = vec_mode;
               dest_d  = dest_reg;
               ptr_d   = '0;
               buf_d   = '0;
            end
         end
         StIssue: begin
            if (ag_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // Write-back outputs are registered here so they are stable for all of WB.
            if (final_cap) begin
               state_d  = StWb;
               rf_wd_d  = buf_d;
               rf_wa_d  = dest_q;
               rf_sel_d = vec_q;
               rf_we_d  = !suppress;
               err_d    = suppress;
               done_d   = 1'b1;
            end
         end
         StWb: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         vec_q    <= 1'b0;
         dest_q   <= '0;
         vld_q    <= '0;
         ptr_q    <= '0;
         buf_q    <= '0;
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
         rf_sel_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         dest_q   <= dest_d;
         vld_q    <= vld_d;
         ptr_q    <= ptr_d;
         buf_q    <= buf_d;
         rf_we_q  <= rf_we_d;
         rf_wa_q  <= rf_wa_d;
         rf_wd_q  <= rf_wd_d;
         rf_sel_q <= rf_sel_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: doc/vector_load_unit.md
Name: vector_load_unit

Overview:
- Write-side producer for the scalar/vector register file.
- On a start pulse, gathers 16 strided 32-bit words from data memory (or 1 word in scalar mode) and assembles them into a 16x32 vector.
- Issues exactly one register-file write cycle (we/addr/data/vector-select).
- Sits between the decode/control path and the register file write port. It is the counterpart of the file's write interface.

Parameters:
- LANES, 16, vector lanes; lane LANES-1 is the scalar lane.
- DW, 32, data and lane width.
- AW, 32, memory address width.
- MEM_LAT, 1, fixed read latency (cycles) from mem_re to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- vec_mode  in  1  1 = vector load (16 words), 0 = scalar load (1 word).
- base_addr  in  AW  address of element 0.
- stride  in  AW  address increment between elements.
- dest_reg  in  4  destination register index.
- mem_re  out  1  memory read enable.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  DW  read data, valid MEM_LAT cycles after mem_re.
- rf_we  out  1  register-file write enable.
- rf_wa  out  4  register-file write address.
- rf_wd  out  LANES x DW  packed write data, lane 15 is the most significant.
- rf_sel_v_s_w  out  1  1 = vector write, 0 = scalar write.
- busy  out  1  high while a load is in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when a scalar write to index 15 is suppressed.

Behaviour:
- Reset:
  - Takes effect on any rising edge with rst=1, including mid-operation.
  - State returns to IDLE; the in-flight load is abandoned and no rf write occurs.
  - All outputs are 0 and the gather buffer is cleared.
- Operand capture: on the edge where start=1 and state is IDLE, latch vec_mode, base_addr, stride and dest_reg. start in any other state is ignored (no queuing).
- Element count: N = 16 if vec_mode=1, else N = 1.
- Element mapping:
  - Element k (k=0..N-1) is read from base_addr + k*stride, computed modulo 2^AW; wrap-around is silent.
  - Element k is stored in lane 15-k, so element 0 lands in the scalar lane.
- States:
  - IDLE: to ISSUE on start.
  - ISSUE: mem_re=1 every cycle; mem_addr starts at base and adds stride each cycle. After N issue cycles, go to DRAIN.
  - DRAIN: wait until all N responses are captured. Go to WB when the final capture completes; with MEM_LAT=1 DRAIN lasts exactly one cycle.
  - WB: rf_we=1 (unless suppressed), done=1, then return to IDLE.
- Response tracking: a MEM_LAT-deep valid shift register plus a lane pointer. mem_rdata is captured on the edge MEM_LAT cycles after its issue cycle.
- Timing, with start sampled at edge 0:
  - mem_re is high in cycles 1..N.
  - WB occurs in cycle N+MEM_LAT+1.
  - busy is high from cycle 1 through the WB cycle inclusive.
  - A new start is accepted in the cycle after WB.
- WB outputs:
  - rf_wa = dest_reg.
  - rf_sel_v_s_w = latched vec_mode.
  - Vector mode: rf_wd holds all 16 lanes.
  - Scalar mode: rf_wd[15] = data and lanes 14..0 = 0.
  - rf_we, rf_wa, rf_wd and rf_sel_v_s_w are registered and stable for the whole WB cycle, so they are safe for a negedge-writing register file.
  - Outside WB, rf_we=0 and rf_wd holds its last value.
- Scalar write to index 15 (the PC alias): rf_we stays 0 in WB, and err=1 together with done=1.
- stride=0: the same address is read N times. This is legal, and every lane gets the same data (given static memory).
- mem_addr when mem_re=0: holds its last value.

Decomposition:
- Package vlu_pkg:
  - LANES, DW, AW constants.
  - typedef lane_t (DW bits) and vec_t (LANES x lane_t, packed).
  - State enum {IDLE, ISSUE, DRAIN, WB}.
  - Scalar-lane index constant, 15.
- One sub-module, vlu_addr_gen: issue counter plus address accumulator (load base, add stride, count N, flag last).
- FSM, response pipeline and gather buffer stay in the top module.

Test Plan:
- Vector load: base=16, stride=1, dest=3, memory[a]=a. Response: mem_re in cycles 1..16 with addr 16..31; WB in cycle 18 with rf_wa=3, rf_sel_v_s_w=1, lane15=16 … lane0=31; done=1 once.
- Scalar load: vec_mode=0, base=50, dest=7, mem[50]=0xDEADBEEF. Response: one read; WB in cycle 3 with rf_sel_v_s_w=0, rf_wd[15]=0xDEADBEEF, lanes 14..0=0.
- Wrap and zero stride:
  - base=0xFFFFFFF8, stride=4: addresses FFFFFFF8, FFFFFFFC, 0, 4, … .
  - stride=0: all 16 lanes hold mem[base].
- Scalar dest=15: no rf_we; err=1 and done=1 in the WB cycle.
- start re-pulsed during ISSUE and DRAIN: ignored, exactly one WB. A start in the cycle after WB is accepted.
- rst asserted in cycle 8 of a vector load: next cycle all outputs are 0 and state is IDLE; no rf_we ever occurs; a subsequent load completes correctly. Repeat with MEM_LAT=3 (WB at cycle 20).
